root_arbiter: RTL and testbench
===============================

ROOT_ARBITER -- requirements
Module: root_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2047: max cycles from core issue to core_out_valid before abort.
REQ-002 SHALL have parameter CNT_W, default 11: width of the timeout counter; CNT_W SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-007 req_data_1_0 / req_data_1_1  input  10 each  radicand for requester 0 / 1.
REQ-008 req_data_2_0 / req_data_2_1  input  3 each  root degree for requester 0 / 1.
REQ-009 rsp_valid  output  2  one-cycle result pulse to the owning requester; one-hot or zero.
REQ-010 rsp_data  output  20  result, shared by both requesters; meaningful only while rsp_valid != 0.
REQ-011 rsp_err  output  1  high with rsp_valid when the operation timed out; rsp_data = 0 in that case.
REQ-012 core_in_valid  output  1  one-cycle start pulse to the root core.
REQ-013 core_in_data_1  output  10  radicand to the core.
REQ-014 core_in_data_2  output  3  degree to the core.
REQ-015 core_out_valid  input  1  core result strobe.
REQ-016 core_out_data  input  20  core result.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, GAP.
REQ-019 IDLE: if any req_valid, grant one requester combinationally, assert its req_ready, latch its data_1/data_2 and id, then go to ISSUE; else stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester. It toggles to the non-granted requester after each grant. A lone requester is always granted.
REQ-021 ISSUE: core_in_valid = 1 for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-022 core_in_data_1/2 SHALL be driven from the latched registers and held stable from ISSUE until the cycle after core_out_valid or timeout. The core reads them throughout the computation.
REQ-023 WAIT: on core_out_valid, capture core_out_data and go to RESP. Otherwise increment the counter.
REQ-024 WAIT timeout: when the counter reaches TIMEOUT without core_out_valid, go to RESP with the error flag set.
REQ-025 RESP: rsp_valid[id] = 1 for one cycle, with rsp_data = captured value and rsp_err = flag; then go to GAP.
REQ-026 GAP: one idle cycle so the core is back in its init state; then go to IDLE. req_ready = 0.
REQ-027 Latency: grant in cycle T gives core_in_valid at T+1; core_out_valid at cycle C gives rsp_valid at C+1; the next grant is no earlier than C+3.
REQ-028 req_ready SHALL be 0 outside IDLE. A request asserted while busy waits; req_valid need not be held beyond its own handshake.
REQ-029 A core_out_valid seen outside WAIT SHALL be ignored. A late result after a timeout SHALL NOT produce a second rsp_valid.
REQ-030 If both req_valid are high in IDLE, only the pointer-selected requester gets req_ready.
REQ-031 Requests with req_data_2 = 0 SHALL be forwarded unchanged; the arbiter performs no range checks.

Reset
REQ-032 On rst_n = 0 at a clock edge: state = IDLE, pointer = 0, counter = 0, latched data = 0, err flag = 0.
REQ-033 All outputs SHALL be 0 during and after reset.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no rsp_valid; the core is reset by the same rst_n.

Structure
REQ-035 The shared package SHALL hold the state encoding (3-bit, IDLE = 0), the result width 20, the radicand width 10 and the degree width 3.
REQ-036 One sub-module, rr_arb2 (2-way round-robin grant with a pointer), is natural; everything else is inline.

Verification
REQ-037 Single request: req0 with data_1 = 16, data_2 = 2; core model returns 20'h00080 after 30 cycles -> core_in_valid one cycle after grant, rsp_valid = 2'b01, rsp_data = 20'h00080, rsp_err = 0.
REQ-038 Contention: both valid from reset, pointer = 0 -> req0 served first, then req1; rsp_valid = 01 then 10; core_in_valid pulses separated by at least 3 cycles.
REQ-039 Fairness: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-040 Timeout: core model never responds, TIMEOUT = 15 -> rsp_valid at 17 cycles after core_in_valid, with rsp_err = 1 and rsp_data = 0; a late core_out_valid is ignored.
REQ-041 Stability: core_in_data_1/2 are checked every cycle from ISSUE to response and must equal the latched request while req_data inputs toggle randomly.
REQ-042 Reset mid-WAIT: rst_n = 0 for 1 cycle -> all outputs 0 at the next edge, no rsp_valid, next request served normally.

Source files
------------

// File: rtl/root_arbiter_pkg.sv
// Shared definitions for the root-core arbiter: datapath widths, FSM
// encoding and the latched request record.
package root_arbiter_pkg;

  localparam int N_REQ = 2;   // number of requesters
  localparam int RES_W = 20;  // root result width
  localparam int RAD_W = 10;  // radicand width
  localparam int DEG_W = 3;   // root degree width

  // Arbiter FSM; IDLE must encode as zero.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Operands captured from the granted requester and forwarded to the core.
  typedef struct packed {
    logic [RAD_W-1:0] radicand;
    logic [DEG_W-1:0] degree;
  } op_t;

endpackage

// File: rtl/root_arbiter_if.sv
// Bundle of requester-side and core-side signals of the root arbiter.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus root core).
interface root_arbiter_if;
  import root_arbiter_pkg::*;

  // Requester side
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [RAD_W-1:0] req_data_1_0;
  logic [RAD_W-1:0] req_data_1_1;
  logic [DEG_W-1:0] req_data_2_0;
  logic [DEG_W-1:0] req_data_2_1;
  logic [N_REQ-1:0] rsp_valid;
  logic [RES_W-1:0] rsp_data;
  logic             rsp_err;

  // Core side
  logic             core_in_valid;
  logic [RAD_W-1:0] core_in_data_1;
  logic [DEG_W-1:0] core_in_data_2;
  logic             core_out_valid;
  logic [RES_W-1:0] core_out_data;

  modport slave (
    input  req_valid, req_data_1_0, req_data_1_1, req_data_2_0, req_data_2_1,
    input  core_out_valid, core_out_data,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output core_in_valid, core_in_data_1, core_in_data_2
  );

  modport master (
    output req_valid, req_data_1_0, req_data_1_1, req_data_2_0, req_data_2_1,
    output core_out_valid, core_out_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  core_in_valid, core_in_data_1, core_in_data_2
  );

endinterface

// File: rtl/root_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred requester;
// after a grant it moves to the requester that was not granted, so a
// continuously requesting pair alternates while a lone requester always wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,   // grant is being taken this cycle
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic ptr_q;

  // Combinational grant: preferred requester first, otherwise the other one.
  always_comb begin
    gnt_any = |req;
    gnt_id  = req[ptr_q] ? ptr_q : ~ptr_q;
    gnt     = '0;
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  // Pointer update: prefer the loser of the current grant next time.
  always_ff @(posedge clk) begin
    if (!rst_n)                  ptr_q <= 1'b0;
    else if (advance && gnt_any) ptr_q <= ~gnt_id;
  end

endmodule

// File: rtl/root_arbiter.sv
// Arbiter sharing one root-extraction core between two requesters.
// Flow per operation: IDLE (grant) -> ISSUE (start pulse) -> WAIT (result or
// timeout) -> RESP (one-cycle response) -> GAP (core settles) -> IDLE.
// All outputs are forced to zero while rst_n is low.
module root_arbiter
  import root_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 2047,  // cycles allowed in WAIT before abort
  parameter int CNT_W   = 11     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  root_arbiter_if.slave  bus,
  output logic           busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_t                op_q;
  logic               id_q;
  logic [RES_W-1:0]   res_q;
  logic               err_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_id;
  logic               arb_any;
  logic               timeout_hit;

  logic [N_REQ-1:0]   req_ready_c;
  logic [N_REQ-1:0]   rsp_valid_c;
  logic               core_in_valid_c;
  logic               busy_c;

  // Grants are only taken in IDLE, so the pointer only moves there.
  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (state_q == ST_IDLE),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id),
    .gnt_any (arb_any)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d         = state_q;
    req_ready_c     = '0;
    rsp_valid_c     = '0;
    core_in_valid_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_c = arb_gnt;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_in_valid_c = 1'b1;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving in the same cycle as the timeout still wins.
        if (bus.core_out_valid || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_c[id_q] = 1'b1;
        state_d           = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_c = (state_q != ST_IDLE);

    // Outputs are quiet throughout reset, not only after the reset edge.
    if (!rst_n) begin
      req_ready_c     = '0;
      rsp_valid_c     = '0;
      core_in_valid_c = 1'b0;
      busy_c          = 1'b0;
    end
  end

  // Operand latch, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand/result registers are reset as well because they
      // drive outputs directly and must read as zero after reset.
      op_q  <= '0;
      id_q  <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            op_q.radicand <= arb_id ? bus.req_data_1_1 : bus.req_data_1_0;
            op_q.degree   <= arb_id ? bus.req_data_2_1 : bus.req_data_2_0;
            id_q          <= arb_id;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          res_q <= '0;
          err_q <= 1'b0;
        end
        ST_WAIT: begin
          if (bus.core_out_valid) begin
            res_q <= bus.core_out_data;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operands stay on the core bus from ISSUE until the next grant.
  assign bus.core_in_data_1 = rst_n ? op_q.radicand : '0;
  assign bus.core_in_data_2 = rst_n ? op_q.degree   : '0;
  assign bus.core_in_valid  = core_in_valid_c;
  assign bus.req_ready      = req_ready_c;
  assign bus.rsp_valid      = rsp_valid_c;
  assign bus.rsp_data       = (|rsp_valid_c) ? res_q : '0;
  assign bus.rsp_err        = (|rsp_valid_c) & err_q;
  assign busy               = busy_c;

endmodule

// File: tb/tb_root_arbiter.sv
// Directed bench for root_arbiter: one default instance (dut) and one with
// TIMEOUT = 15 (dut_to) for the abort path. Inputs change 2 time units after
// the rising edge and outputs are sampled 1 unit later.
module tb_root_arbiter;
  import root_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc = 0;

  root_arbiter_if a ();
  root_arbiter_if b ();

  root_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave),
    .busy  (busy_a)
  );

  root_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave),
    .busy  (busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    a.req_valid = '0; a.req_data_1_0 = '0; a.req_data_1_1 = '0;
    a.req_data_2_0 = '0; a.req_data_2_1 = '0;
    a.core_out_valid = 1'b0; a.core_out_data = '0;
    b.req_valid = '0; b.req_data_1_0 = '0; b.req_data_1_1 = '0;
    b.req_data_2_0 = '0; b.req_data_2_1 = '0;
    b.core_out_valid = 1'b0; b.core_out_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full operation on dut, entered in an IDLE cycle with req_valid driven.
  // The core model answers 'lat' cycles after the start pulse.
  task automatic do_op(input string tag, input int lat, input logic [19:0] res,
                       input logic [1:0] eg, input logic [9:0] e1,
                       input logic [2:0] e2, input bit drop, input bit toggle);
    #1;
    checks++;
    if (a.req_ready !== eg) begin
      errors++; $display("FAIL %s grant: got %b want %b", tag, a.req_ready, eg);
    end
    tick();
    if (drop) a.req_valid = a.req_valid & ~eg;
    #1;
    issue_cyc = cyc;
    checks++;
    if ({a.core_in_valid, a.core_in_data_1, a.core_in_data_2} !== {1'b1, e1, e2}) begin
      errors++;
      $display("FAIL %s issue: got v=%b d1=%0d d2=%0d want v=1 d1=%0d d2=%0d",
               tag, a.core_in_valid, a.core_in_data_1, a.core_in_data_2, e1, e2);
    end
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (toggle) begin
        a.req_data_1_0 = 10'($urandom); a.req_data_1_1 = 10'($urandom);
        a.req_data_2_0 = 3'($urandom);  a.req_data_2_1 = 3'($urandom);
      end
      #1;
      checks++;
      if ({a.core_in_valid, a.req_ready, a.rsp_valid, a.core_in_data_1, a.core_in_data_2}
          !== {1'b0, 2'b00, 2'b00, e1, e2}) begin
        errors++;
        $display("FAIL %s wait k=%0d: got v=%b rdy=%b rsp=%b d1=%0d d2=%0d want 0/00/00/%0d/%0d",
                 tag, k, a.core_in_valid, a.req_ready, a.rsp_valid,
                 a.core_in_data_1, a.core_in_data_2, e1, e2);
      end
      if (k == lat) begin
        a.core_out_valid = 1'b1;
        a.core_out_data  = res;
      end
    end
    tick();
    a.core_out_valid = 1'b0;
    a.core_out_data  = 20'hFFFFF;
    #1;
    checks++;
    if ({a.rsp_valid, a.rsp_err, a.rsp_data, a.core_in_data_1, a.core_in_data_2}
        !== {eg, 1'b0, res, e1, e2}) begin
      errors++;
      $display("FAIL %s resp: got v=%b err=%b data=%h d1=%0d d2=%0d want v=%b err=0 data=%h",
               tag, a.rsp_valid, a.rsp_err, a.rsp_data, a.core_in_data_1,
               a.core_in_data_2, eg, res);
    end
    tick();
    #1;
    checks++;
    if ({a.rsp_valid, a.req_ready, busy_a} !== {2'b00, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL %s gap: got rsp=%b rdy=%b busy=%b want 00/00/1",
               tag, a.rsp_valid, a.req_ready, busy_a);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    a.req_valid = 2'b11; a.req_data_1_0 = 10'd5; a.req_data_2_0 = 3'd1;
    b.req_valid = 2'b01; b.req_data_1_0 = 10'd9; b.req_data_2_0 = 3'd2;
    #1;
    checks++;
    if ({a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_data, a.core_in_valid,
         a.core_in_data_1, a.core_in_data_2, busy_a} !== '0) begin
      errors++; $display("FAIL reset_during: a outputs not zero, got rdy=%b busy=%b",
                         a.req_ready, busy_a);
    end
    tick();
    tick();
    #1;
    checks++;
    if ({a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_data, a.core_in_valid,
         a.core_in_data_1, a.core_in_data_2, busy_a} !== '0) begin
      errors++; $display("FAIL reset_a: outputs not zero, got rdy=%b civ=%b busy=%b",
                         a.req_ready, a.core_in_valid, busy_a);
    end
    checks++;
    if ({b.req_ready, b.rsp_valid, b.rsp_err, b.rsp_data, b.core_in_valid,
         b.core_in_data_1, b.core_in_data_2, busy_b} !== '0) begin
      errors++; $display("FAIL reset_b: outputs not zero, got rdy=%b busy=%b",
                         b.req_ready, busy_b);
    end
    clear_inputs();
    rst_n = 1'b1;
    tick();
    #1;
    checks++;
    if ({a.req_ready, a.rsp_valid, a.core_in_valid, a.core_in_data_1, busy_a} !== '0) begin
      errors++; $display("FAIL reset_after: got rdy=%b rsp=%b civ=%b d1=%0d busy=%b want 0",
                         a.req_ready, a.rsp_valid, a.core_in_valid, a.core_in_data_1, busy_a);
    end
    tick();
  endtask

  task automatic test_single();
    a.req_valid = 2'b01;
    a.req_data_1_0 = 10'd16;  a.req_data_2_0 = 3'd2;
    a.req_data_1_1 = 10'd999; a.req_data_2_1 = 3'd7;
    do_op("single", 30, 20'h00080, 2'b01, 10'd16, 3'd2, 1'b1, 1'b0);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy got %b want 0", busy_a);
    end
  endtask

  task automatic test_contention();
    int first_issue;
    do_reset();
    a.req_valid = 2'b11;
    a.req_data_1_0 = 10'd100; a.req_data_2_0 = 3'd3;
    a.req_data_1_1 = 10'd200; a.req_data_2_1 = 3'd5;
    do_op("cont0", 5, 20'h11111, 2'b01, 10'd100, 3'd3, 1'b1, 1'b0);
    first_issue = issue_cyc;
    do_op("cont1", 5, 20'h22222, 2'b10, 10'd200, 3'd5, 1'b1, 1'b0);
    // result at issue+5, next grant no earlier than result+3, issue one later
    checks++;
    if (issue_cyc - first_issue < 9) begin
      errors++; $display("FAIL cont_spacing: issue gap got %0d want >= 9",
                         issue_cyc - first_issue);
    end
  endtask

  task automatic test_fairness();
    a.req_valid = 2'b11;
    a.req_data_1_0 = 10'd7; a.req_data_2_0 = 3'd1;
    a.req_data_1_1 = 10'd9; a.req_data_2_1 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        do_op("fair", 2, 20'(i * 3 + 1), 2'b01, 10'd7, 3'd1, 1'b0, 1'b0);
      else
        do_op("fair", 2, 20'(i * 3 + 1), 2'b10, 10'd9, 3'd0, 1'b0, 1'b0);
    end
    a.req_valid = 2'b00;
  endtask

  task automatic test_stability();
    a.req_valid = 2'b10;
    a.req_data_1_1 = 10'h3A5; a.req_data_2_1 = 3'd6;
    a.req_data_1_0 = 10'h011; a.req_data_2_0 = 3'd2;
    do_op("stab", 8, 20'hABCDE, 2'b10, 10'h3A5, 3'd6, 1'b1, 1'b1);
  endtask

  task automatic test_stray_result();
    a.req_valid = 2'b00;
    a.core_out_valid = 1'b1; a.core_out_data = 20'h12345;
    tick();
    a.core_out_valid = 1'b0;
    #1;
    checks++;
    if ({a.rsp_valid, busy_a} !== 3'b000) begin
      errors++; $display("FAIL stray: got rsp=%b busy=%b want 00/0", a.rsp_valid, busy_a);
    end
    tick();
  endtask

  task automatic test_timeout();
    b.req_valid = 2'b10;
    b.req_data_1_1 = 10'd500; b.req_data_2_1 = 3'd4;
    b.req_data_1_0 = 10'd1;   b.req_data_2_0 = 3'd1;
    #1;
    checks++;
    if (b.req_ready !== 2'b10) begin
      errors++; $display("FAIL to_grant: got %b want 10", b.req_ready);
    end
    tick();
    b.req_valid = 2'b00;
    #1;
    checks++;
    if ({b.core_in_valid, b.core_in_data_1, b.core_in_data_2} !== {1'b1, 10'd500, 3'd4}) begin
      errors++; $display("FAIL to_issue: got v=%b d1=%0d d2=%0d want 1/500/4",
                         b.core_in_valid, b.core_in_data_1, b.core_in_data_2);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      #1;
      checks++;
      if ({b.rsp_valid, b.core_in_data_1} !== {2'b00, 10'd500}) begin
        errors++; $display("FAIL to_wait k=%0d: got rsp=%b d1=%0d want 00/500",
                           k, b.rsp_valid, b.core_in_data_1);
      end
    end
    tick();
    #1;
    checks++;
    if ({b.rsp_valid, b.rsp_err, b.rsp_data} !== {2'b10, 1'b1, 20'h0}) begin
      errors++; $display("FAIL to_resp: got v=%b err=%b data=%h want 10/1/00000",
                         b.rsp_valid, b.rsp_err, b.rsp_data);
    end
    tick();
    b.core_out_valid = 1'b1; b.core_out_data = 20'h55555;
    #1;
    checks++;
    if ({b.rsp_valid, b.rsp_err} !== 3'b000) begin
      errors++; $display("FAIL to_gap: got rsp=%b err=%b want 00/0", b.rsp_valid, b.rsp_err);
    end
    tick();
    b.core_out_valid = 1'b0;
    #1;
    checks++;
    if ({b.rsp_valid, busy_b} !== 3'b000) begin
      errors++; $display("FAIL to_late: got rsp=%b busy=%b want 00/0", b.rsp_valid, busy_b);
    end
    tick();
    #1;
    checks++;
    if (b.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL to_late2: got rsp=%b want 00", b.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    a.req_valid = 2'b01;
    a.req_data_1_0 = 10'd33; a.req_data_2_0 = 3'd2;
    #1;
    checks++;
    if (a.req_ready !== 2'b01) begin
      errors++; $display("FAIL rmid_grant: got %b want 01", a.req_ready);
    end
    tick();
    a.req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, a.core_in_data_1} !== {1'b0, 10'd0}) begin
      errors++; $display("FAIL rmid_during: got busy=%b d1=%0d want 0/0",
                         busy_a, a.core_in_data_1);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_data, a.core_in_valid,
         a.core_in_data_1, a.core_in_data_2, busy_a} !== '0) begin
      errors++; $display("FAIL rmid_after: got rsp=%b civ=%b d1=%0d busy=%b want 0",
                         a.rsp_valid, a.core_in_valid, a.core_in_data_1, busy_a);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++;
      if ({a.rsp_valid, busy_a} !== 3'b000) begin
        errors++; $display("FAIL rmid_quiet k=%0d: got rsp=%b busy=%b want 00/0",
                           k, a.rsp_valid, busy_a);
      end
    end
    a.req_valid = 2'b10;
    a.req_data_1_1 = 10'd64; a.req_data_2_1 = 3'd3;
    do_op("rmid_next", 4, 20'h00040, 2'b10, 10'd64, 3'd3, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_stability();
    test_stray_result();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
